// File: rtl/correction_scheduler_if.sv
// Qubit correction bus: per-channel error flags/correction pulses plus the
// valid/ready event report channel towards the decoder.
interface correction_scheduler_if #(
    parameter int unsigned NUM_QUBITS = 8
);
    logic [NUM_QUBITS-1:0] error_state;
    logic [NUM_QUBITS-1:0] apply_correction;
    logic                  evt_valid;
    logic [4:0]            evt_qubit;
    logic                  evt_ready;

    modport master (
        input  error_state,
        input  evt_ready,
        output apply_correction,
        output evt_valid,
        output evt_qubit
    );

    modport slave (
        output error_state,
        output evt_ready,
        input  apply_correction,
        input  evt_valid,
        input  evt_qubit
    );
endinterface

// File: rtl/correction_scheduler.sv
// Round-robin correction controller: picks a flagged qubit, waits out the
// measurement latency, pulses its correction line and reports the event.
module correction_scheduler #(
    parameter int unsigned NUM_QUBITS   = 8,
    parameter int unsigned MEAS_LATENCY = 4,
    parameter int unsigned COOLDOWN     = 2,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clear_counts,
    correction_scheduler_if.master bus,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  corr_count,
    output logic [CNT_WIDTH-1:0]  spurious_count
);
    localparam int unsigned TW = $clog2(NUM_QUBITS);

    typedef enum logic [2:0] {IDLE, MEASURE, CORRECT, REPORT, COOL} state_e;

    state_e                state_q, state_d;
    logic [7:0]            timer_q, timer_d;
    logic [TW-1:0]         target_q, target_d;
    logic [TW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [NUM_QUBITS-1:0] apply_q, apply_d;
    logic                  evt_valid_q, evt_valid_d;
    logic [CNT_WIDTH-1:0]  corr_q, corr_d;
    logic [CNT_WIDTH-1:0]  spur_q, spur_d;

    logic [TW-1:0]         grant;
    logic                  grant_vld;
    logic [TW-1:0]         next_target;
    logic                  target_err;
    int unsigned           idx;

    assign target_err  = bus.error_state[target_q];
    assign next_target = (target_q == TW'(NUM_QUBITS - 1)) ? '0 : target_q + 1'b1;

    // Scan from rr_ptr upwards with wrap; first set flag wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_QUBITS; i++) begin
            idx = (32'(rr_ptr_q) + i) % NUM_QUBITS;
            if (!grant_vld && bus.error_state[TW'(idx)]) begin
                grant     = TW'(idx);
                grant_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        target_d = target_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (enable && grant_vld) begin
                    target_d = grant;
                    timer_d  = 8'(MEAS_LATENCY - 1);
                    state_d  = MEASURE;
                end
            end
            MEASURE: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    rr_ptr_d = next_target;
                    state_d  = target_err ? CORRECT : IDLE;
                end
            end
            CORRECT: state_d = REPORT;
            REPORT: begin
                if (evt_valid_q && bus.evt_ready) begin
                    if (COOLDOWN == 0) begin
                        state_d = IDLE;
                    end else begin
                        timer_d = 8'(COOLDOWN - 1);
                        state_d = COOL;
                    end
                end
            end
            COOL: begin
                if (timer_q != '0) timer_d = timer_q - 1'b1;
                else               state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pulse/valid flops are loaded from the next state so the outputs are glitch-free.
    always_comb begin
        apply_d     = '0;
        evt_valid_d = (state_d == REPORT);
        if (state_d == CORRECT) apply_d[target_q] = 1'b1;
        corr_d = corr_q;
        spur_d = spur_q;
        if (clear_counts) begin
            corr_d = '0;
            spur_d = '0;
        end else begin
            if (state_q == CORRECT && corr_q != '1) corr_d = corr_q + 1'b1;
            if (state_q == MEASURE && timer_q == '0 && !target_err && spur_q != '1)
                spur_d = spur_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q     <= '0;
            target_q    <= '0;
            rr_ptr_q    <= '0;
            apply_q     <= '0;
            evt_valid_q <= 1'b0;
            corr_q      <= '0;
            spur_q      <= '0;
        end else begin
            timer_q     <= timer_d;
            target_q    <= target_d;
            rr_ptr_q    <= rr_ptr_d;
            apply_q     <= apply_d;
            evt_valid_q <= evt_valid_d;
            corr_q      <= corr_d;
            spur_q      <= spur_d;
        end
    end

    assign bus.apply_correction = apply_q;
    assign bus.evt_valid        = evt_valid_q;
    assign bus.evt_qubit        = 5'(target_q);
    assign busy                 = (state_q != IDLE);
    assign corr_count           = corr_q;
    assign spurious_count       = spur_q;
endmodule

// File: tb/tb_correction_scheduler.sv
// Directed + randomized service sequences checked against a timestamp-level
// model of the scheduler; a second 2-bit-counter instance checks saturation.
module tb_correction_scheduler;
    localparam int unsigned NQ = 8;
    localparam int unsigned L  = 4;
    localparam int unsigned C  = 2;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       clear_counts;
    logic [7:0] err;
    logic       rdy;
    logic       busy_a, busy_b;
    logic [15:0] corr_a, spur_a;
    logic [1:0]  corr_b, spur_b;

    int unsigned n_pass, n_total, n_fail;
    int unsigned m_corr, m_spur, m_rr;

    correction_scheduler_if #(.NUM_QUBITS(NQ)) bus_a ();
    correction_scheduler_if #(.NUM_QUBITS(NQ)) bus_b ();

    assign bus_a.error_state = err;
    assign bus_a.evt_ready   = rdy;
    assign bus_b.error_state = err;
    assign bus_b.evt_ready   = rdy;

    correction_scheduler #(
        .NUM_QUBITS(NQ), .MEAS_LATENCY(L), .COOLDOWN(C), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear_counts(clear_counts),
        .bus(bus_a), .busy(busy_a), .corr_count(corr_a), .spurious_count(spur_a)
    );

    correction_scheduler #(
        .NUM_QUBITS(NQ), .MEAS_LATENCY(L), .COOLDOWN(C), .CNT_WIDTH(2)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear_counts(clear_counts),
        .bus(bus_b), .busy(busy_b), .corr_count(corr_b), .spurious_count(spur_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sat(input int unsigned m, input int unsigned mx);
        return (m > mx) ? mx : m;
    endfunction

    // First flagged index at or above the pointer, wrapping.
    function automatic int unsigned pick(input logic [7:0] p, input int unsigned rr);
        for (int unsigned i = 0; i < NQ; i++)
            if (p[(rr + i) % NQ]) return (rr + i) % NQ;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_counts();
        chk("corr_count",     32'(corr_a), sat(m_corr, 16'hFFFF));
        chk("spurious_count", 32'(spur_a), sat(m_spur, 16'hFFFF));
        chk("corr_sat",       32'(corr_b), sat(m_corr, 3));
        chk("spur_sat",       32'(spur_b), sat(m_spur, 3));
    endtask

    // Check one cycle's outputs mid-cycle, then advance to just after the next edge.
    task automatic cyc(input bit eb, input logic [7:0] ea, input bit ev, input int unsigned eq);
        @(negedge clk);
        chk("busy", 32'(busy_a), 32'(eb));
        chk("apply_correction", 32'(bus_a.apply_correction), 32'(ea));
        chk("evt_valid", 32'(bus_a.evt_valid), 32'(ev));
        if (ev) chk("evt_qubit", 32'(bus_a.evt_qubit), eq);
        chk_counts();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_busy"},  32'(busy_a), 0);
        chk({tag, "_apply"}, 32'(bus_a.apply_correction), 0);
        chk({tag, "_valid"}, 32'(bus_a.evt_valid), 0);
        chk({tag, "_qubit"}, 32'(bus_a.evt_qubit), 0);
        chk({tag, "_corr"},  32'(corr_a), 0);
        chk({tag, "_spur"},  32'(spur_a), 0);
        chk({tag, "_corr2"}, 32'(corr_b), 0);
        chk({tag, "_spur2"}, 32'(spur_b), 0);
    endtask

    task automatic reset_now(input string tag);
        rst_n = 1'b0;
        #1;
        reset_vals(tag);
        m_corr = 0; m_spur = 0; m_rr = 0;
        err = '0; enable = 1'b0; clear_counts = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle_off(input int unsigned n, input bit clr);
        for (int unsigned i = 0; i < n; i++) begin
            enable = 1'b0;
            err = 8'($urandom);
            rdy = 1'($urandom);
            clear_counts = clr && (i == 0);
            cyc(1'b0, 8'h00, 1'b0, 0);
            if (clr && i == 0) begin m_corr = 0; m_spur = 0; end
        end
        clear_counts = 1'b0;
    endtask

    // One complete service starting from an IDLE cycle with pattern pat.
    task automatic service(input logic [7:0] pat, input bit spur, input int unsigned drop_at,
                           input int unsigned bp, input bit clr);
        int unsigned g;
        logic [7:0]  gm;
        g  = pick(pat, m_rr);
        gm = 8'(1) << g;
        err = pat; enable = 1'b1; clear_counts = 1'b0; rdy = 1'($urandom);
        cyc(1'b0, 8'h00, 1'b0, 0);
        for (int unsigned k = 1; k <= L; k++) begin
            enable = 1'($urandom);
            rdy = 1'($urandom);
            err = (8'($urandom) & ~gm) | ((spur && k >= drop_at) ? 8'h00 : gm);
            cyc(1'b1, 8'h00, 1'b0, 0);
        end
        m_rr = (g + 1) % NQ;
        if (spur) begin
            m_spur++;
            return;
        end
        clear_counts = clr;
        cyc(1'b1, gm, 1'b0, 0);
        clear_counts = 1'b0;
        if (clr) begin m_corr = 0; m_spur = 0; end
        else m_corr++;
        enable = 1'b1;
        for (int unsigned b = 0; b < bp; b++) begin
            err = 8'($urandom) & ~gm;
            rdy = 1'b0;
            cyc(1'b1, 8'h00, 1'b1, g);
        end
        err = 8'($urandom) & ~gm;
        rdy = 1'b1;
        cyc(1'b1, 8'h00, 1'b1, g);
        for (int unsigned c = 0; c < C; c++) begin
            rdy = 1'($urandom);
            err = 8'($urandom);
            cyc(1'b1, 8'h00, 1'b0, 0);
        end
    endtask

    initial begin
        int unsigned g;
        n_pass = 0; n_total = 0; n_fail = 0;
        m_corr = 0; m_spur = 0; m_rr = 0;
        rst_n = 1'b0; enable = 1'b0; clear_counts = 1'b0; err = '0; rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_vals("reset");
        rst_n = 1'b1;

        idle_off(6, 1'b0);
        service(8'h08, 1'b0, 1, 0, 1'b0);
        reset_now("rst_idle");

        service(8'h85, 1'b0, 1, 0, 1'b0);
        service(8'h84, 1'b0, 1, 0, 1'b0);
        service(8'h80, 1'b0, 1, 0, 1'b0);
        service(8'h01, 1'b0, 1, 0, 1'b0);

        service(8'h20, 1'b1, 2, 0, 1'b0);
        service(8'h10, 1'b0, 1, 7, 1'b0);

        repeat (4) service(8'h02, 1'b0, 1, 0, 1'b0);
        service(8'h40, 1'b0, 1, 0, 1'b1);
        idle_off(1, 1'b0);

        repeat (40) begin
            service(8'($urandom_range(1, 255)), ($urandom % 4) == 0, $urandom_range(1, L),
                    ($urandom % 3 == 0) ? $urandom_range(1, 7) : 0, ($urandom % 8) == 0);
            if ($urandom % 3 == 0) idle_off($urandom_range(1, 3), ($urandom % 4) == 0);
        end

        err = 8'h40; enable = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 0);
        err = 8'h40;
        cyc(1'b1, 8'h00, 1'b0, 0);
        reset_now("rst_measure");

        service(8'h04, 1'b0, 1, 0, 1'b0);
        g = pick(8'h40, m_rr);
        err = 8'h40; enable = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 0);
        repeat (L) cyc(1'b1, 8'h00, 1'b0, 0);
        @(negedge clk);
        chk("correct_before_rst", 32'(bus_a.apply_correction), 32'(8'(1) << g));
        reset_now("rst_correct");

        idle_off(2, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/correction_scheduler.md
# correction_scheduler

Closed-loop correction controller that sits directly downstream of a bank of `noise_channel` instances and drives their correction inputs. It watches every qubit's `error_state` line and picks one flagged qubit with round-robin arbitration. After a modelled measurement latency it pulses that qubit's `apply_correction` for one cycle, then reports the event to the decoder/CPU over a valid/ready handshake. It also keeps saturating statistics counters.

## Interface
- `NUM_QUBITS`, 8: number of monitored channels; legal range 2..32.
- `MEAS_LATENCY`, 4: cycles spent in MEASURE; legal range 1..255.
- `COOLDOWN`, 2: idle cycles after each report; legal range 0..255.
- `CNT_WIDTH`, 16: width of the statistics counters.

Ports (name, direction, width, meaning):
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  active-low asynchronous reset; deassertion is synchronised externally.
- `enable`  in  1  permits starting a new service; an in-flight service always completes.
- `error_state`  in  NUM_QUBITS  level error flags, one per noise channel.
- `apply_correction`  out  NUM_QUBITS  one-hot correction pulse, one bit per noise channel.
- `evt_valid`  out  1  event report valid.
- `evt_qubit`  out  5  index of the serviced qubit.
- `evt_ready`  in  1  event consumer ready.
- `clear_counts`  in  1  synchronous clear of both statistics counters.
- `busy`  out  1  high whenever the FSM state is not IDLE.
- `corr_count`  out  CNT_WIDTH  completed corrections, saturating.
- `spurious_count`  out  CNT_WIDTH  aborted services, saturating.

## Operation
- FSM states: IDLE, MEASURE, CORRECT, REPORT, COOL.
- **IDLE.** If `enable` and `|error_state`, the arbiter grants the lowest index at or above `rr_ptr` (wrapping), latches it into `target`, loads `timer = MEAS_LATENCY-1`, and moves to MEASURE. Otherwise the FSM stays in IDLE.
- **MEASURE.** While `timer != 0`, decrement `timer`. When `timer == 0`:
  - if `error_state[target]` is set, go to CORRECT;
  - otherwise increment `spurious_count` and return to IDLE. `rr_ptr` still advances on this path.
- **CORRECT.** Lasts exactly one cycle. `apply_correction[target]` is 1; all other bits are 0. `corr_count` increments. Next state is REPORT.
- **REPORT.**
  - `evt_valid` = 1 and `evt_qubit` = `target`; both hold stable until `evt_ready`.
  - On the cycle with `evt_valid && evt_ready`: if `COOLDOWN == 0` go to IDLE; otherwise load `timer = COOLDOWN-1` and go to COOL.
- **COOL.** Decrement `timer`; at 0 go to IDLE.
- **Round-robin.** When a service ends (CORRECT entered, or spurious abort), `rr_ptr <= (target+1) mod NUM_QUBITS`.
- **Output drive.** `apply_correction` is driven from a flop that is set on the transition into CORRECT, so it is glitch-free. `evt_valid` is registered the same way.
- **Counters.**
  - Both counters saturate at all-ones.
  - `clear_counts` zeroes both; if it coincides with an increment, clear wins.
  - Counter width arithmetic is unsigned.
- **`enable` low** only blocks the IDLE→MEASURE transition. It has no effect in any other state.
- **Other requests.** Error lines that rise while the FSM is busy are not latched. They are level-held by the noise channels and get serviced in a later IDLE.

## Timing
- **Reset values.** The FSM is in IDLE. `apply_correction`=0, `evt_valid`=0, `evt_qubit`=0, `busy`=0, `corr_count`=0, `spurious_count`=0, `rr_ptr`=0, `timer`=0.
- **Asynchronous reset.** Assertion forces `apply_correction` and `evt_valid` low immediately and discards any in-flight service.
- **Detection-to-correction latency.** If the request is sampled in IDLE at cycle N, `apply_correction` is high during cycle N+1+MEAS_LATENCY.
- **Report timing.** `evt_valid` rises at cycle N+2+MEAS_LATENCY. With `evt_ready` held high, the handshake completes in that same cycle.
- **Full service length.** With `evt_ready` held high, one service takes MEAS_LATENCY+2+COOLDOWN cycles from IDLE back to IDLE.
- **Interaction with `noise_channel`.** The correction clears that channel's `error_state` on the next edge, so `error_state[target]` reads 0 by the time the FSM reaches REPORT.
- **Back-to-back requests** for the same qubit need at least one IDLE cycle between services.

## Test plan
- **Single error, ready held high.** Reset, `enable`=1, raise `error_state[3]` at cycle 10 with defaults. Required: `apply_correction` = 8'h08 for exactly cycle 15, `evt_valid` with `evt_qubit`=3 at cycle 16, `corr_count`=1, `busy` low from cycle 19.
- **Round-robin fairness.** Hold `error_state` = 8'b1000_0101. Required: bits 0, 2 and 7 are corrected in that order. `rr_ptr` then wraps and bit 0 is serviced next if it is re-raised.
- **Spurious abort.** Raise bit 5, then drop it before the MEASURE timer expires. Required: no `apply_correction` pulse, `spurious_count`=1, `evt_valid` never asserts, and the FSM is back in IDLE after MEAS_LATENCY+1 cycles.
- **Backpressure.** Hold `evt_ready` low for 7 cycles during REPORT. Required: `evt_valid` and `evt_qubit` stay stable, no new service starts, and COOL begins the cycle after `evt_ready` rises.
- **Reset mid-service.** Assert `rst_n` low while in MEASURE, and separately while in CORRECT. Required: all outputs are at their reset values without waiting for a clock edge, and both counters are 0.
- **Saturation and clear.** Use `CNT_WIDTH`=2 and perform 5 corrections. Required: `corr_count` sticks at 3. Assert `clear_counts` in the same cycle as a CORRECT. Required: `corr_count`=0.
